dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-master, one-slave arbiter for the data-memory bus feeding the memory/IO controller. Master 0 is the CPU data port; master 1 is a secondary requester (DMA or debug loader). The block holds a registered grant and switches owners round-robin with a burst cap. It drives the single slave port and returns per-master ack, read data and a CPU stall.

Parameters:
AW, 32, address width of master and slave ports
DW, 32, data width
MAX_BURST, 4, max consecutive acked transactions by one owner while the other master waits (legal range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
m0_req  in  1  master 0 request; held with addr/wr/wdata stable until m0_ack
m0_wr  in  1  master 0 write (1) / read (0)
m0_addr  in  AW  master 0 address
m0_wdata  in  DW  master 0 write data
m0_rdata  out  DW  master 0 read data, valid while m0_ack=1
m0_ack  out  1  master 0 transaction accepted this cycle
m0_stall  out  1  m0_req & ~m0_ack, used to freeze the CPU
m1_req, m1_wr, m1_addr, m1_wdata, m1_rdata, m1_ack  (same as master 0)
s_ce  out  1  slave chip enable (memCe)
s_wr  out  1  slave write (memWr)
s_addr  out  AW  slave address
s_wdata  out  DW  slave write data
s_rdata  in  DW  slave read data (combinational from slave)
owner  out  2  0=IDLE, 1=master 0, 2=master 1 (registered state)

Behaviour:
- State is {owner, last_served (1b), cnt}. cnt is sized for 0..MAX_BURST.
- Reset (rst=0, async): owner=IDLE, cnt=0, last_served=1, so master 0 wins the first tie. All outputs that depend on owner go low: s_ce=0, s_wr=0, acks=0, stall=req.
- Slave mux is combinational from owner:
  - owner=Mi: s_ce=mi_req, s_wr=mi_req&mi_wr, s_addr=mi_addr, s_wdata=mi_wdata.
  - owner=IDLE: s_ce=0, s_wr=0, s_addr=0, s_wdata=0.
- mi_ack = (owner==Mi) & mi_req. Both m0_rdata and m1_rdata equal s_rdata; the value is meaningful only when that master's ack is 1.
- Each ack cycle is one complete transaction. The slave write commits at the clk edge that ends the ack cycle. If req is still high in the following cycle, that is a new transaction.
- Latency: a request seen in IDLE is granted at the next edge and acked in the following cycle (1 wait cycle). A continuing owner gets back-to-back acks with 0 wait cycles.
- Next-state at each rising edge, using current-cycle req values:
  - IDLE: both req -> the master other than last_served; one req -> that master; none -> IDLE. cnt=0.
  - Owner O, other master X:
    - n = cnt + ack_O.
    - If req_X and (~req_O or n>=MAX_BURST): owner=X, cnt=0, last_served=O.
    - Else if req_O: stay O, cnt=n.
    - Else (no req): owner=IDLE, cnt=0, last_served=O.
- MAX_BURST=1 gives strict alternation under continuous contention.
- Owner drops req in the same cycle the other raises req: switch at that edge.
- A non-owner requesting alone never waits more than 1 cycle, plus MAX_BURST cycles when the owner is bursting.
- Reset asserted mid-transaction drops ownership immediately. The unacked transaction is abandoned, not completed, and the master must re-request.
- Requester rule: a master must not change addr/wr/wdata or deassert req before ack. Violating this is undefined; no assertion is required in RTL.

Test Plan:
- Reset then idle: after rst 0->1 with no req, owner=0, s_ce=0, m0_stall=0 for 10 cycles. Raise m0_req (read, addr 0x10) -> owner=1 next edge; m0_ack=1 one cycle later; m0_rdata=s_rdata; m0_stall=1 for exactly 1 cycle.
- First tie: m0_req and m1_req rise together after reset -> master 0 granted first; master 1 granted at the edge after m0 drops req.
- Contention burst cap, MAX_BURST=4: both hold req continuously with writes (m0 to 0x100.., m1 to 0x200..) -> ack pattern m0 x4, m1 x4, m0 x4; never more than 4 consecutive; slave sees exactly those addr/data.
- MAX_BURST=1 contention: acks strictly alternate m0,m1,m0,m1 every cycle after the first grant.
- Handoff: m0 owner drops req while m1 raises req in the same cycle -> owner=2 at that edge; m1_ack the next cycle; no IDLE cycle in between.
- Async reset mid-write: assert rst low between edges while owner=2 with s_wr=1 -> s_ce/s_wr/m1_ack drop without waiting for clk, owner=0; after release, m1 re-requests and is re-granted with 1 wait cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response bundle between one data-memory master
// and the arbiter.
//   req    master request, held with wr/addr/wdata stable until ack
//   wr     1 = write, 0 = read
//   addr   transaction address (AW bits)
//   wdata  write data (DW bits)
//   rdata  read data returned by the arbiter, meaningful while ack=1
//   ack    transaction accepted in this cycle
//   stall  req & ~ack, used to freeze a CPU-style master
// Modport master is the requester's view. Modport slave is the arbiter's view.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          stall;

  modport master (output req, wr, addr, wdata, input rdata, ack, stall);
  modport slave  (input req, wr, addr, wdata, output rdata, ack, stall);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master, one-slave data-memory bus arbiter.
// A registered owner selects which master reaches the slave. Ownership
// rotates round-robin. A burst cap forces a handoff after MAX_BURST acked
// transactions while the other master is waiting.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   m0       master 0 (CPU data port), slave modport
//   m1       master 1 (DMA / debug loader), slave modport
//   s_ce     slave chip enable
//   s_wr     slave write strobe
//   s_addr   slave address
//   s_wdata  slave write data
//   s_rdata  slave read data (combinational from the slave)
//   owner    0 = idle, 1 = master 0, 2 = master 1 (registered)
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        m0,
  dmem_arbiter_if.slave        m1,
  output logic                 s_ce,
  output logic                 s_wr,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wdata,
  input  logic [DW-1:0]        s_rdata,
  output logic [1:0]           owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } owner_t;

  // The burst counter holds 0..MAX_BURST. The next count needs one extra
  // bit so that the compare against the cap cannot wrap.
  localparam int            CW    = $clog2(MAX_BURST + 1);
  localparam logic [CW:0]   MAX_N = (CW+1)'(MAX_BURST);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

  owner_t        own_q, own_d, other;
  logic          last_q, last_d;   // 0 = master 0 served last, 1 = master 1
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_o, req_x;
  logic [CW:0]   n;

  // A lone owner may keep bursting past the cap. The count is therefore
  // held at the cap instead of being allowed to overflow.
  function automatic logic [CW-1:0] sat_cnt(input logic [CW:0] v);
    if (v >= MAX_N) return MAX_C;
    return v[CW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_q  <= IDLE;
      last_q <= 1'b1;   // master 0 wins the first tie after reset
      cnt_q  <= '0;
    end else begin
      own_q  <= own_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    own_d  = own_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    req_o  = 1'b0;
    req_x  = 1'b0;
    other  = IDLE;
    n      = '0;
    case (own_q)
      OWN_M0, OWN_M1: begin
        if (own_q == OWN_M0) begin
          req_o = m0.req;
          req_x = m1.req;
          other = OWN_M1;
        end else begin
          req_o = m1.req;
          req_x = m0.req;
          other = OWN_M0;
        end
        // The owner's request in this cycle is also its ack.
        n = {1'b0, cnt_q} + {{CW{1'b0}}, req_o};
        if (req_x && (!req_o || n >= MAX_N)) begin
          own_d  = other;
          cnt_d  = '0;
          last_d = (own_q == OWN_M1);
        end else if (req_o) begin
          cnt_d = sat_cnt(n);
        end else begin
          own_d  = IDLE;
          cnt_d  = '0;
          last_d = (own_q == OWN_M1);
        end
      end
      default: begin
        cnt_d = '0;
        if (m0.req && m1.req) own_d = last_q ? OWN_M0 : OWN_M1;
        else if (m0.req)      own_d = OWN_M0;
        else if (m1.req)      own_d = OWN_M1;
        else                  own_d = IDLE;
      end
    endcase
  end

  // The slave mux and the acks depend only on the registered owner and the
  // live requests. An async reset therefore drops them without a clock edge.
  always_comb begin
    s_ce    = 1'b0;
    s_wr    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    case (own_q)
      OWN_M0: begin
        s_ce    = m0.req;
        s_wr    = m0.req & m0.wr;
        s_addr  = m0.addr;
        s_wdata = m0.wdata;
      end
      OWN_M1: begin
        s_ce    = m1.req;
        s_wr    = m1.req & m1.wr;
        s_addr  = m1.addr;
        s_wdata = m1.wdata;
      end
      default: ;
    endcase
  end

  assign m0.ack   = (own_q == OWN_M0) & m0.req;
  assign m1.ack   = (own_q == OWN_M1) & m1.req;
  assign m0.stall = m0.req & ~m0.ack;
  assign m1.stall = m1.req & ~m1.ack;
  assign m0.rdata = s_rdata;
  assign m1.rdata = s_rdata;
  assign owner    = own_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter.
// Two instances share one set of master stimulus: dut_a uses MAX_BURST=4 and
// dut_b uses MAX_BURST=1. use_b selects which instance is observed. Each
// slave returns read data derived from its address, so the expected read
// data follows from the address alone.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        use_b = 1'b0;
  logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int          who;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;
  txn_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction
  function automatic logic [31:0] base_of(input int who, input int i);
    return (who == 0 ? 32'h0000_0100 : 32'h0000_0200) + 32'(4 * i);
  endfunction
  function automatic logic [31:0] data_of(input int who, input int i);
    return (who == 0 ? 32'hD000_0000 : 32'hE100_0000) | 32'(i);
  endfunction

  dmem_arbiter_if #(.AW(32), .DW(32)) ia0 ();
  dmem_arbiter_if #(.AW(32), .DW(32)) ia1 ();
  dmem_arbiter_if #(.AW(32), .DW(32)) ib0 ();
  dmem_arbiter_if #(.AW(32), .DW(32)) ib1 ();

  assign ia0.req = m0_req; assign ia0.wr = m0_wr; assign ia0.addr = m0_addr; assign ia0.wdata = m0_wdata;
  assign ia1.req = m1_req; assign ia1.wr = m1_wr; assign ia1.addr = m1_addr; assign ia1.wdata = m1_wdata;
  assign ib0.req = m0_req; assign ib0.wr = m0_wr; assign ib0.addr = m0_addr; assign ib0.wdata = m0_wdata;
  assign ib1.req = m1_req; assign ib1.wr = m1_wr; assign ib1.addr = m1_addr; assign ib1.wdata = m1_wdata;

  logic        sa_ce, sa_wr, sb_ce, sb_wr;
  logic [31:0] sa_addr, sa_wdata, sa_rdata, sb_addr, sb_wdata, sb_rdata;
  logic [1:0]  sa_owner, sb_owner;

  assign sa_rdata = rd_model(sa_addr);
  assign sb_rdata = rd_model(sb_addr);

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .m0(ia0), .m1(ia1),
    .s_ce(sa_ce), .s_wr(sa_wr), .s_addr(sa_addr), .s_wdata(sa_wdata),
    .s_rdata(sa_rdata), .owner(sa_owner)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .m0(ib0), .m1(ib1),
    .s_ce(sb_ce), .s_wr(sb_wr), .s_addr(sb_addr), .s_wdata(sb_wdata),
    .s_rdata(sb_rdata), .owner(sb_owner)
  );

  logic        o_ack0, o_ack1, o_stall0, o_ce, o_wr;
  logic [31:0] o_addr, o_wdata, o_rd0, o_rd1;
  logic [1:0]  o_owner;
  assign o_ack0   = use_b ? ib0.ack   : ia0.ack;
  assign o_ack1   = use_b ? ib1.ack   : ia1.ack;
  assign o_stall0 = use_b ? ib0.stall : ia0.stall;
  assign o_rd0    = use_b ? ib0.rdata : ia0.rdata;
  assign o_rd1    = use_b ? ib1.rdata : ia1.rdata;
  assign o_ce     = use_b ? sb_ce     : sa_ce;
  assign o_wr     = use_b ? sb_wr     : sa_wr;
  assign o_addr   = use_b ? sb_addr   : sa_addr;
  assign o_wdata  = use_b ? sb_wdata  : sa_wdata;
  assign o_owner  = use_b ? sb_owner  : sa_owner;

  task automatic do_reset();
    m0_req = 1'b0; m1_req = 1'b0; m0_wr = 1'b0; m1_wr = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    int stalls;
    use_b = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++; if (o_owner !== 2'd0) $display("FAIL reset_owner got %0d want 0", o_owner); else passed++;
    checks++; if ({o_ce, o_wr, o_ack0, o_ack1} !== 4'b0) $display("FAIL reset_outputs got %b want 0000", {o_ce, o_wr, o_ack0, o_ack1}); else passed++;
    m0_req = 1'b1; #1;
    checks++; if ({o_stall0, o_ack0} !== 2'b10) $display("FAIL reset_stall_eq_req got %b want 10", {o_stall0, o_ack0}); else passed++;
    m0_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if ({o_owner, o_ce, o_stall0} !== 4'b0) $display("FAIL idle_cycle%0d got %b want 0000", i, {o_owner, o_ce, o_stall0}); else passed++;
    end
    @(posedge clk); #1 m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h10;
    stalls = 0;
    @(negedge clk);
    if (o_stall0) stalls++;
    checks++; if ({o_owner, o_ack0} !== 3'b000) $display("FAIL first_wait got %b want 000", {o_owner, o_ack0}); else passed++;
    @(negedge clk);
    if (o_stall0) stalls++;
    checks++; if ({o_owner, o_ack0, o_ce, o_wr} !== 5'b01110) $display("FAIL first_grant got %b want 01110", {o_owner, o_ack0, o_ce, o_wr}); else passed++;
    checks++; if (o_rd0 !== rd_model(32'h10)) $display("FAIL first_rdata got %h want %h", o_rd0, rd_model(32'h10)); else passed++;
    checks++; if (o_addr !== 32'h10) $display("FAIL first_saddr got %h want 10", o_addr); else passed++;
    @(posedge clk); #1 m0_req = 1'b0;
    @(negedge clk);
    if (o_stall0) stalls++;
    checks++; if (stalls !== 1) $display("FAIL stall_cycles got %0d want 1", stalls); else passed++;
  endtask

  task automatic test_first_tie();
    use_b = 1'b0;
    do_reset();
    @(posedge clk); #1;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h20;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h40;
    @(negedge clk);
    checks++; if ({o_ack0, o_ack1} !== 2'b00) $display("FAIL tie_wait got %b want 00", {o_ack0, o_ack1}); else passed++;
    @(negedge clk);
    checks++; if ({o_owner, o_ack0, o_ack1} !== 4'b0110) $display("FAIL tie_m0_first got %b want 0110", {o_owner, o_ack0, o_ack1}); else passed++;
    checks++; if (o_rd0 !== rd_model(32'h20)) $display("FAIL tie_rdata0 got %h want %h", o_rd0, rd_model(32'h20)); else passed++;
    @(posedge clk); #1 m0_req = 1'b0;
    @(negedge clk);
    checks++; if ({o_owner, o_ack1} !== 3'b010) $display("FAIL tie_m1_waits got %b want 010", {o_owner, o_ack1}); else passed++;
    @(negedge clk);
    checks++; if ({o_owner, o_ack1} !== 3'b101) $display("FAIL tie_m1_grant got %b want 101", {o_owner, o_ack1}); else passed++;
    checks++; if (o_rd1 !== rd_model(32'h40)) $display("FAIL tie_rdata1 got %h want %h", o_rd1, rd_model(32'h40)); else passed++;
    @(posedge clk); #1 m1_req = 1'b0;
  endtask

  task automatic test_handoff();
    use_b = 1'b0;
    do_reset();
    @(posedge clk); #1 m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h50;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({o_owner, o_ack0} !== 3'b011) $display("FAIL handoff_m0_ack got %b want 011", {o_owner, o_ack0}); else passed++;
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h60;
    @(negedge clk);
    checks++; if ({o_owner, o_ack0, o_ack1} !== 4'b0100) $display("FAIL handoff_mid got %b want 0100", {o_owner, o_ack0, o_ack1}); else passed++;
    @(negedge clk);
    checks++; if ({o_owner, o_ack1} !== 3'b101) $display("FAIL handoff_m1_ack got %b want 101", {o_owner, o_ack1}); else passed++;
    @(posedge clk); #1 m1_req = 1'b0;
  endtask

  task automatic test_async_reset();
    use_b = 1'b0;
    do_reset();
    @(posedge clk); #1 m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 32'h300; m1_wdata = 32'hCAFE_0001;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({o_owner, o_ce, o_wr, o_ack1} !== 5'b10111) $display("FAIL areset_pre got %b want 10111", {o_owner, o_ce, o_wr, o_ack1}); else passed++;
    #2 rst = 1'b0;
    #1;
    checks++; if ({o_owner, o_ce, o_wr, o_ack1} !== 5'b00000) $display("FAIL areset_drop got %b want 00000", {o_owner, o_ce, o_wr, o_ack1}); else passed++;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if ({o_owner, o_ack1} !== 3'b000) $display("FAIL areset_rewait got %b want 000", {o_owner, o_ack1}); else passed++;
    @(negedge clk);
    checks++; if ({o_owner, o_ack1, o_wr} !== 4'b1011) $display("FAIL areset_regrant got %b want 1011", {o_owner, o_ack1, o_wr}); else passed++;
    checks++; if ({o_addr, o_wdata} !== {32'h300, 32'hCAFE_0001}) $display("FAIL areset_bus got %h/%h want 300/cafe0001", o_addr, o_wdata); else passed++;
    @(posedge clk); #1 m1_req = 1'b0;
  endtask

  // Both masters write continuously. The expected ack order alternates in
  // groups of 'burst'. Each master advances its address on its own ack.
  task automatic test_contention(input int burst, input int total, input logic sel);
    int   c0, c1, i0, i1, seen, run, run_who, cyc, prev_cyc, who;
    logic a0, a1;
    txn_t t, e;
    use_b = sel;
    do_reset();
    sb.delete();
    c0 = 0; c1 = 0;
    for (int k = 0; k < total; k++) begin
      t.who  = (k / burst) % 2;
      t.addr = base_of(t.who, t.who == 0 ? c0 : c1);
      t.data = data_of(t.who, t.who == 0 ? c0 : c1);
      if (t.who == 0) c0++; else c1++;
      sb.push_back(t);
    end
    i0 = 0; i1 = 0;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = base_of(0, 0); m0_wdata = data_of(0, 0);
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = base_of(1, 0); m1_wdata = data_of(1, 0);
    seen = 0; run = 0; run_who = -1; cyc = 0; prev_cyc = 0;
    while (seen < total && cyc < 80) begin
      @(negedge clk);
      cyc++;
      a0 = o_ack0; a1 = o_ack1;
      if (a0 || a1) begin
        checks++; if (a0 && a1) $display("FAIL b%0d_dual_ack cycle %0d got 11 want one-hot", burst, cyc); else passed++;
        who = a1 ? 1 : 0;
        if (sb.size() == 0) begin
          checks++; $display("FAIL b%0d_extra_ack cycle %0d got ack want none", burst, cyc);
        end else begin
          e = sb.pop_front();
          checks++; if (who !== e.who) $display("FAIL b%0d_order txn %0d got m%0d want m%0d", burst, seen, who, e.who); else passed++;
          checks++; if (o_addr !== e.addr) $display("FAIL b%0d_saddr txn %0d got %h want %h", burst, seen, o_addr, e.addr); else passed++;
          checks++; if (o_wdata !== e.data) $display("FAIL b%0d_swdata txn %0d got %h want %h", burst, seen, o_wdata, e.data); else passed++;
          checks++; if ({o_ce, o_wr} !== 2'b11) $display("FAIL b%0d_swr txn %0d got %b want 11", burst, seen, {o_ce, o_wr}); else passed++;
        end
        if (who == run_who) run++; else run = 1;
        run_who = who;
        checks++; if (run > burst) $display("FAIL b%0d_cap txn %0d got run %0d want <=%0d", burst, seen, run, burst); else passed++;
        if (seen > 0) begin
          checks++; if (cyc != prev_cyc + 1) $display("FAIL b%0d_gap txn %0d got %0d idle want 0", burst, seen, cyc - prev_cyc - 1); else passed++;
        end
        prev_cyc = cyc;
        seen++;
      end
      @(posedge clk); #1;
      if (a0) begin i0++; m0_addr = base_of(0, i0); m0_wdata = data_of(0, i0); end
      if (a1) begin i1++; m1_addr = base_of(1, i1); m1_wdata = data_of(1, i1); end
      if (seen >= total) begin m0_req = 1'b0; m1_req = 1'b0; end
    end
    checks++; if (seen != total) $display("FAIL b%0d_timeout got %0d acks want %0d", burst, seen, total); else passed++;
    m0_req = 1'b0; m1_req = 1'b0;
    use_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_tie();
    test_handoff();
    test_contention(4, 12, 1'b0);
    test_contention(1, 8, 1'b1);
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
